sayeh_memory_responder: RTL and testbench

- Memory-side responder for the SAYEH CPU address/data interface.
- Accepts read/write requests qualified by readMem/writeMem on the 16-bit address bus driven by the CPU address path.
- Inserts a programmable number of wait states, then completes the transfer with a one-cycle memDataReady pulse.
- Backs a synchronous on-chip word RAM and flags protocol violations. Sits between the CPU datapath/controller and program/data storage.

---
 rtl/sayeh_memory_responder.sv | 171 +++++++++++++++++
 tb/tb_sayeh_memory_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sayeh_memory_responder.sv
// Memory-side responder for the SAYEH CPU bus: wait-state insertion in front of a
// word RAM, one-cycle completion pulse, and protocol/range violation reporting.
module sayeh_memory_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned WAIT_STATES = 2,
    parameter int unsigned RANGE_CHECK = 1
) (
    input  logic        clk,
    input  logic        ExternalReset,
    input  logic [15:0] Addressbus,
    input  logic [15:0] DataIn,
    input  logic        readMem,
    input  logic        writeMem,
    output logic [15:0] DataOut,
    output logic        memDataReady,
    output logic        protErr,
    output logic        busy
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned CNT_W  = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_READY,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                rdy_q, rdy_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic                range_err_c;
    logic                req_c;
    logic                opp_c;
    logic                done_c;
    logic                done_wr_c;
    logic                mem_we_c;
    logic [ADDR_W-1:0]   mem_addr_c;
    logic [DATA_W-1:0]   mem_wdata_c;

    assign range_err_c = (RANGE_CHECK != 0) && ((Addressbus >> ADDR_W) != 16'd0);
    assign req_c       = wr_q ? writeMem : readMem;
    assign opp_c       = wr_q ? readMem  : writeMem;

    // Next-state, access and output decode; completion funnels through done_c.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        wr_d        = wr_q;
        dout_d      = dout_q;
        rdy_d       = 1'b0;
        err_d       = 1'b0;
        done_c      = 1'b0;
        done_wr_c   = wr_q;
        mem_addr_c  = addr_q;
        mem_wdata_c = data_q;

        case (state_q)
            S_IDLE: begin
                if (readMem && writeMem) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (readMem || writeMem) begin
                    if (range_err_c) begin
                        err_d   = 1'b1;
                        state_d = S_RELEASE;
                    end else begin
                        addr_d = Addressbus[ADDR_W-1:0];
                        data_d = DataIn;
                        wr_d   = writeMem;
                        if (WAIT_STATES == 0) begin
                            // No wait states: access straight from the live bus.
                            done_c      = 1'b1;
                            done_wr_c   = writeMem;
                            mem_addr_c  = Addressbus[ADDR_W-1:0];
                            mem_wdata_c = DataIn;
                        end else begin
                            cnt_d   = CNT_INIT;
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                if (!req_c) begin
                    state_d = S_IDLE;
                end else if (opp_c) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (cnt_q == '0) begin
                    done_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_READY: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (!readMem && !writeMem) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (done_c) begin
            state_d = S_READY;
            rdy_d   = 1'b1;
            if (!done_wr_c) begin
                dout_d = mem_q[mem_addr_c];
            end
        end

        mem_we_c = done_c && done_wr_c && !ExternalReset;
        busy_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge ExternalReset) begin
        if (ExternalReset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_q    <= 1'b0;
            dout_q  <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_q    <= wr_d;
            dout_q  <= dout_d;
            rdy_q   <= rdy_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem_q[mem_addr_c] <= mem_wdata_c;
        end
    end

    assign DataOut      = dout_q;
    assign memDataReady = rdy_q;
    assign protErr      = err_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_sayeh_memory_responder.sv
// Scoreboard bench: two responders (2 wait states + range check, 0 wait states + aliasing)
// driven by directed and random transactions against a transaction-level memory model.
module tb_sayeh_memory_responder;

    localparam int K_RD  = 0;
    localparam int K_WR  = 1;
    localparam int K_ERR = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [15:0] data;
        bit          dk;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       rd_i, wr_i;
    logic [1:0][15:0] addr_i, din_i, dout;
    logic [1:0]       rdy, err, busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    ev_t         exp_q [2][$];
    logic [15:0] mem_m [2][256];
    bit          known [2][256];
    logic [15:0] last_rd [2];
    bit          last_k  [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sayeh_memory_responder #(.ADDR_W(8), .WAIT_STATES(2), .RANGE_CHECK(1)) u_dut0 (
        .clk(clk), .ExternalReset(rst), .Addressbus(addr_i[0]), .DataIn(din_i[0]),
        .readMem(rd_i[0]), .writeMem(wr_i[0]), .DataOut(dout[0]),
        .memDataReady(rdy[0]), .protErr(err[0]), .busy(busy[0])
    );

    sayeh_memory_responder #(.ADDR_W(8), .WAIT_STATES(0), .RANGE_CHECK(0)) u_dut1 (
        .clk(clk), .ExternalReset(rst), .Addressbus(addr_i[1]), .DataIn(din_i[1]),
        .readMem(rd_i[1]), .writeMem(wr_i[1]), .DataOut(dout[1]),
        .memDataReady(rdy[1]), .protErr(err[1]), .busy(busy[1])
    );

    function automatic int ws_of(input int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic bit rc_of(input int k);
        return (k == 0);
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0h exp=%0h at cycle %0d", name, k, got, exp, cyc);
        end
    endtask

    // Monitor: every ready/error pulse must match the head of the expected queue.
    always @(negedge clk) begin
        ev_t e;
        if (!rst) begin
            for (int k = 0; k < 2; k++) begin
                check("ready_err_overlap", k, 32'(rdy[k] & err[k]), 32'd0);
                if (rdy[k] || err[k]) begin
                    if (exp_q[k].size() == 0) begin
                        check("unexpected_event", k, 32'({rdy[k], err[k]}), 32'd0);
                    end else begin
                        e = exp_q[k].pop_front();
                        check("event_kind", k, 32'({rdy[k], err[k]}), (e.kind == K_ERR) ? 32'd1 : 32'd2);
                        check("event_cycle", k, 32'(cyc), 32'(e.cyc));
                        if (e.kind != K_ERR && e.dk)
                            check(e.kind == K_RD ? "read_data" : "dout_hold_on_write", k, 32'(dout[k]), 32'(e.data));
                    end
                end else if (exp_q[k].size() != 0 && exp_q[k][0].cyc <= cyc) begin
                    e = exp_q[k].pop_front();
                    check("missing_event", k, 32'({rdy[k], err[k]}), (e.kind == K_ERR) ? 32'd1 : 32'd2);
                end
            end
        end
    end

    // One bus transaction; called just after a rising edge. opp>0 raises the
    // opposite strobe so it is seen at the opp-th edge after acceptance.
    task automatic txn(input int k, input bit r, input bit w, input logic [15:0] a,
                       input logic [15:0] d, input int hold, input int opp);
        ev_t e;
        int  t0, ws, idx;
        bit  rerr;
        t0   = cyc + 1;
        ws   = ws_of(k);
        idx  = int'(a[7:0]);
        rerr = rc_of(k) && (a[15:8] != 8'h00);
        e.data = 16'h0;
        e.dk   = 1'b0;
        if ((r && w) || rerr) begin
            e.kind = K_ERR; e.cyc = t0; exp_q[k].push_back(e);
        end else if (opp >= 1 && opp <= ws) begin
            e.kind = K_ERR; e.cyc = t0 + opp; exp_q[k].push_back(e);
        end else if (hold > ws) begin
            e.cyc = t0 + ws;
            if (w) begin
                e.kind = K_WR; e.data = last_rd[k]; e.dk = last_k[k];
                mem_m[k][idx] = d;
                known[k][idx] = 1'b1;
            end else begin
                e.kind = K_RD; e.data = mem_m[k][idx]; e.dk = known[k][idx];
                last_rd[k] = mem_m[k][idx];
                last_k[k]  = known[k][idx];
            end
            exp_q[k].push_back(e);
        end
        rd_i[k] = r; wr_i[k] = w; addr_i[k] = a; din_i[k] = d;
        for (int j = 1; j < hold; j++) begin
            @(posedge clk); #1;
            addr_i[k] = 16'($urandom);
            din_i[k]  = 16'($urandom);
            if (opp == j && !(r && w)) begin
                if (r) wr_i[k] = 1'b1; else rd_i[k] = 1'b1;
            end
        end
        @(posedge clk); #1;
        rd_i[k] = 1'b0; wr_i[k] = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int k, sel, hold, opp;
        logic [15:0] a;
        rst = 1'b1; rd_i = '0; wr_i = '0; addr_i = '0; din_i = '0;
        for (int i = 0; i < 2; i++) begin
            last_rd[i] = 16'h0; last_k[i] = 1'b1;
            for (int j = 0; j < 256; j++) begin mem_m[i][j] = 16'h0; known[i][j] = 1'b0; end
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_dout", i, 32'(dout[i]), 32'h0);
            check("reset_ready", i, 32'(rdy[i]), 32'h0);
            check("reset_err", i, 32'(err[i]), 32'h0);
            check("reset_busy", i, 32'(busy[i]), 32'h0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        txn(0, 0, 1, 16'h0005, 16'hBEEF, 4, 0);
        txn(0, 1, 0, 16'h0005, 16'h0000, 4, 0);
        txn(1, 1, 0, 16'h0007, 16'h0000, 5, 0);
        txn(0, 1, 0, 16'h0005, 16'h0000, 2, 0);
        check("busy_after_abort", 0, 32'(busy[0]), 32'h0);
        txn(0, 1, 0, 16'h0005, 16'h0000, 3, 0);
        txn(0, 1, 1, 16'h0005, 16'h0000, 3, 0);
        txn(0, 0, 1, 16'h0000, 16'h1111, 3, 0);
        txn(0, 0, 1, 16'h0100, 16'h2222, 3, 0);
        txn(0, 1, 0, 16'h0000, 16'h0000, 3, 0);
        txn(1, 0, 1, 16'h0103, 16'h1234, 2, 0);
        txn(1, 1, 0, 16'h0003, 16'h0000, 2, 0);
        txn(0, 1, 0, 16'h0005, 16'h0000, 4, 1);

        // Reset in the middle of a write: outputs clear at once, RAM keeps old data.
        txn(0, 0, 1, 16'h0010, 16'hAAAA, 4, 0);
        wr_i[0] = 1'b1; addr_i[0] = 16'h0010; din_i[0] = 16'h5555;
        @(posedge clk); #1;
        check("busy_in_wait", 0, 32'(busy[0]), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midreset_dout", 0, 32'(dout[0]), 32'h0);
        check("midreset_ready", 0, 32'(rdy[0]), 32'h0);
        check("midreset_err", 0, 32'(err[0]), 32'h0);
        check("midreset_busy", 0, 32'(busy[0]), 32'h0);
        wr_i[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 2; i++) begin last_rd[i] = 16'h0; last_k[i] = 1'b1; end
        @(posedge clk); #1;
        txn(0, 1, 0, 16'h0010, 16'h0000, 3, 0);

        for (int n = 0; n < 120; n++) begin
            k    = int'($urandom_range(1, 0));
            sel  = int'($urandom_range(15, 0));
            hold = int'($urandom_range(6, 1));
            opp  = ($urandom_range(7, 0) == 0) ? int'($urandom_range(3, 1)) : 0;
            a    = 16'($urandom_range(15, 0));
            if (k == 1 || $urandom_range(7, 0) == 0) a[15:8] = 8'($urandom);
            if (sel == 0) txn(k, 1, 1, a, 16'($urandom), hold, 0);
            else          txn(k, sel[0], !sel[0], a, 16'($urandom), hold, opp);
        end

        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) check("pending_events", i, 32'(exp_q[i].size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
